soc1_cpu_cpu_div_cell: RTL and testbench
========================================

// Module: soc1_cpu_cpu_div_cell
// PURPOSE
//   Iterative radix-2 restoring divider for the soc1 CPU, complementary to the DSP multiplier cell.
//   Accepts E_src1 (dividend) / E_src2 (divisor) on a start pulse and returns quotient and remainder
//   after a fixed latency. Supports signed and unsigned operation.
//   Sits beside the mult cell in the execute/memory stages; the pipeline stalls on D_busy.
// PARAMETERS
//   DATA_W   32   operand/result width; even, >= 4
//   CNT_W    6    iteration counter width; must satisfy 2**CNT_W > DATA_W
// PORTS
//   clk           in   1       core clock; all state updates on rising edge
//   reset_n       in   1       asynchronous active-low reset
//   E_src1        in   DATA_W  dividend, sampled on the accepted start edge
//   E_src2        in   DATA_W  divisor, sampled on the accepted start edge
//   E_div_start   in   1       start request; honoured only in IDLE
//   E_div_signed  in   1       1 = two's-complement operands, 0 = unsigned
//   M_flush       in   1       synchronous abort of any in-flight divide
//   D_busy        out  1       high from the accepted start edge until the done edge
//   D_done        out  1       single-cycle pulse; results valid and held from this cycle
//   D_quotient    out  DATA_W  quotient
//   D_remainder   out  DATA_W  remainder
//   D_div_zero    out  1       divisor was zero; held alongside the results
// BEHAVIOUR
//   - Reset: state=IDLE; D_busy=0, D_done=0, D_quotient=0, D_remainder=0, D_div_zero=0; counter=0.
//   - FSM states: IDLE -> RUN -> FIXUP -> IDLE.
//   - IDLE, on E_div_start=1 at edge T:
//       - Latch |src1| and |src2| (absolute value only if E_div_signed), the sign flags, and the zero flag.
//       - Clear the partial remainder; set counter=DATA_W-1; go to RUN; D_busy=1.
//   - RUN, one iteration per edge (DATA_W edges, T+1..T+DATA_W):
//       - Form {rem,dvd} << 1; trial = rem - divisor (DATA_W+1 bits).
//       - If trial >= 0: rem=trial and quotient bit=1; else keep rem and quotient bit=0.
//       - Counter decrements; at 0 go to FIXUP.
//   - FIXUP (edge T+DATA_W+1):
//       - Negate the quotient if signed and the operand signs differ.
//       - Negate the remainder if signed and the dividend was negative (remainder takes the sign of the dividend).
//       - Register the outputs, pulse D_done=1 for one cycle, drop D_busy, go to IDLE.
//   - Total latency: D_done is high in the cycle after edge T+DATA_W+1 (DATA_W+2 edges after start).
//   - Divisor zero: the iterations still run (fixed latency).
//       - D_quotient = all ones, D_remainder = original E_src1 (unsigned and signed), D_div_zero=1.
//   - Signed overflow (most-negative / -1): D_quotient = 0x8000_0000 (for DATA_W=32), D_remainder=0,
//     D_div_zero=0. This falls out of the magnitude path plus the wrap in the negate.
//   - E_div_start while D_busy: ignored; the in-flight operation is unaffected.
//   - E_div_start in the same cycle as D_done: the FSM is already in IDLE, so the start is accepted.
//   - M_flush=1: return to IDLE next edge; D_busy=0; no D_done.
//       - Result registers keep their previous values.
//       - Flush takes priority over start in the same cycle.
//   - Reset mid-operation: immediate return to the reset state; no D_done.
//   - Results and D_div_zero hold until the next FIXUP updates them.
// CONFIGURATION
//   SOC1_DIV_REMAINDER_EN
//     - Defined: D_remainder is computed and registered as described above.
//     - Undefined: the remainder fixup and output register are removed and D_remainder is tied to 0.
//       The divide-by-zero remainder is also 0. Quotient, latency and flags are unchanged.
// TESTING
//   - Unsigned 100/7, start pulse -> D_done 34 edges later; q=14, r=2, D_div_zero=0; D_busy high 33 cycles.
//   - Signed -7/2 (0xFFFFFFF9/0x2) -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1); signed 7/-2 -> q=-3, r=1.
//   - Divide by zero: 0x1234/0 -> q=0xFFFFFFFF, r=0x1234, D_div_zero=1, same latency.
//   - Signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; unsigned same operands -> q=0, r=0x80000000.
//   - Start 50/5; M_flush at edge T+10 -> D_busy=0 at T+11, no D_done, outputs unchanged.
//     New start at T+12 with 9/4 -> q=2, r=1.
//   - Second start pulse during RUN ignored. Back-to-back start coincident with D_done accepted.
//     async reset_n low mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/soc1_cpu_cpu_div_cell.sv
// soc1_cpu_cpu_div_cell
//   Iterative radix-2 restoring divider beside the mult cell in execute/memory.
//   A start pulse in IDLE latches operand magnitudes. DATA_W iterations then run,
//   one per clock, followed by one sign fix-up cycle. D_done pulses once the
//   results are registered. Signed and unsigned operation are supported, and the
//   latency is fixed at DATA_W+2 edges, including for a zero divisor.
//
//   Optional feature macro: SOC1_DIV_REMAINDER_EN
//     defined   : D_remainder is computed, sign-fixed and registered
//     undefined : D_remainder is tied to 0 (quotient, latency and flags unchanged)
//
// Ports
//   clk           core clock, rising edge
//   reset_n       asynchronous active-low reset
//   E_src1        dividend, sampled on the accepted start edge
//   E_src2        divisor, sampled on the accepted start edge
//   E_div_start   start request, honoured only in IDLE
//   E_div_signed  1 = two's-complement operands
//   M_flush       synchronous abort of an in-flight divide (wins over start)
//   D_busy        high from the accepted start edge until the done edge
//   D_done        single-cycle completion pulse
//   D_quotient    quotient, held until the next completion
//   D_remainder   remainder (sign of the dividend), held until the next completion
//   D_div_zero    divisor was zero, held alongside the results
module soc1_cpu_cpu_div_cell #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] E_src1,
    input  logic [DATA_W-1:0] E_src2,
    input  logic              E_div_start,
    input  logic              E_div_signed,
    input  logic              M_flush,
    output logic              D_busy,
    output logic              D_done,
    output logic [DATA_W-1:0] D_quotient,
    output logic [DATA_W-1:0] D_remainder,
    output logic              D_div_zero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FIXUP = 2'd2
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] rem_q;      // partial remainder
    logic [DATA_W-1:0] dvd_q;      // dividend bits shift out, quotient bits shift in
    logic [DATA_W-1:0] dsr_q;      // divisor magnitude
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_quo_q;
    logic              zero_q;
`ifdef SOC1_DIV_REMAINDER_EN
    logic              neg_rem_q;
`endif

    // Operand magnitudes and sign flags for the start edge
    logic              src1_neg_c;
    logic              src2_neg_c;
    logic [DATA_W-1:0] src1_abs_c;
    logic [DATA_W-1:0] src2_abs_c;

    assign src1_neg_c = E_div_signed & E_src1[DATA_W-1];
    assign src2_neg_c = E_div_signed & E_src2[DATA_W-1];
    assign src1_abs_c = src1_neg_c ? ({DATA_W{1'b0}} - E_src1) : E_src1;
    assign src2_abs_c = src2_neg_c ? ({DATA_W{1'b0}} - E_src2) : E_src2;

    // One restoring step. The partial remainder stays below the divisor, so a
    // DATA_W-bit difference is exact whenever the trial succeeds.
    logic [DATA_W:0]   shifted_c;
    logic              trial_ok_c;
    logic [DATA_W-1:0] rem_next_c;

    assign shifted_c  = {rem_q, dvd_q[DATA_W-1]};
    assign trial_ok_c = (shifted_c >= {1'b0, dsr_q});
    assign rem_next_c = trial_ok_c ? (shifted_c[DATA_W-1:0] - dsr_q) : shifted_c[DATA_W-1:0];

    // Sign fix-up; a zero divisor always reports an all-ones quotient
    logic [DATA_W-1:0] quo_fix_c;
    assign quo_fix_c = zero_q    ? {DATA_W{1'b1}} :
                       neg_quo_q ? ({DATA_W{1'b0}} - dvd_q) : dvd_q;

`ifdef SOC1_DIV_REMAINDER_EN
    logic [DATA_W-1:0] rem_fix_c;
    assign rem_fix_c = neg_rem_q ? ({DATA_W{1'b0}} - rem_q) : rem_q;
`else
    assign D_remainder = {DATA_W{1'b0}};
`endif

    // Control FSM, datapath and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            cnt_q       <= '0;
            neg_quo_q   <= 1'b0;
            zero_q      <= 1'b0;
`ifdef SOC1_DIV_REMAINDER_EN
            neg_rem_q   <= 1'b0;
            D_remainder <= '0;
`endif
            D_busy      <= 1'b0;
            D_done      <= 1'b0;
            D_quotient  <= '0;
            D_div_zero  <= 1'b0;
        end else begin
            D_done <= 1'b0;
            if (M_flush) begin
                state_q <= S_IDLE;
                D_busy  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (E_div_start) begin
                            rem_q     <= '0;
                            dvd_q     <= src1_abs_c;
                            dsr_q     <= src2_abs_c;
                            neg_quo_q <= src1_neg_c ^ src2_neg_c;
                            zero_q    <= (E_src2 == {DATA_W{1'b0}});
`ifdef SOC1_DIV_REMAINDER_EN
                            neg_rem_q <= src1_neg_c;
`endif
                            cnt_q     <= CNT_W'(DATA_W - 1);
                            D_busy    <= 1'b1;
                            state_q   <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        rem_q <= rem_next_c;
                        dvd_q <= {dvd_q[DATA_W-2:0], trial_ok_c};
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == '0) begin
                            state_q <= S_FIXUP;
                        end
                    end
                    S_FIXUP: begin
                        D_quotient  <= quo_fix_c;
`ifdef SOC1_DIV_REMAINDER_EN
                        D_remainder <= rem_fix_c;
`endif
                        D_div_zero  <= zero_q;
                        D_done      <= 1'b1;
                        D_busy      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        D_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_soc1_cpu_cpu_div_cell.sv
// Bench for soc1_cpu_cpu_div_cell: vector table plus hand-written corner
// sequences; expected results are queued on start and compared on D_done.
module tb_soc1_cpu_cpu_div_cell;

`ifdef SOC1_DIV_REMAINDER_EN
    localparam bit REM_EN = 1'b1;
`else
    localparam bit REM_EN = 1'b0;
`endif
    localparam int unsigned LAT  = 34;
    localparam int unsigned BUSY = 33;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] E_src1;
    logic [31:0] E_src2;
    logic        E_div_start;
    logic        E_div_signed;
    logic        M_flush;
    logic        D_busy;
    logic        D_done;
    logic [31:0] D_quotient;
    logic [31:0] D_remainder;
    logic        D_div_zero;

    soc1_cpu_cpu_div_cell #(.DATA_W(32), .CNT_W(6)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .E_src1       (E_src1),
        .E_src2       (E_src2),
        .E_div_start  (E_div_start),
        .E_div_signed (E_div_signed),
        .M_flush      (M_flush),
        .D_busy       (D_busy),
        .D_done       (D_done),
        .D_quotient   (D_quotient),
        .D_remainder  (D_remainder),
        .D_div_zero   (D_div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[13];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] rexp(input logic [31:0] r);
        return REM_EN ? r : 32'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: every D_done must match the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (D_done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'(D_done), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("quotient", D_quotient, e.q);
                    check("remainder", D_remainder, rexp(e.r));
                    check("div_zero", 32'(D_div_zero), 32'(e.z));
                end
            end
        end
    end

    // Caller is at a negedge. Drives one start, queues the expectation and waits
    // (bounded) for D_done; extra_at>0 pulses a second start during RUN.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic [31:0] q, input logic [31:0] r, input logic z,
                          input int extra_at);
        int cyc;
        int busy_cyc;
        bit seen;
        exp_t e;
        e.q = q; e.r = r; e.z = z;
        sb_q.push_back(e);
        E_src1 = a; E_src2 = b; E_div_signed = sgn; E_div_start = 1'b1;
        cyc = 0; busy_cyc = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            E_div_start = (extra_at != 0 && cyc == extra_at);
            if (E_div_start) begin
                E_src1 = 32'd9; E_src2 = 32'd4;
            end
            if (D_busy === 1'b1) busy_cyc++;
            if (D_done === 1'b1) seen = 1'b1;
        end
        E_div_start = 1'b0;
        check("latency", 32'(cyc), 32'(LAT));
        check("busy_cycles", 32'(busy_cyc), 32'(BUSY));
    endtask

    initial begin
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        ua;
        logic [31:0]        ub;

        vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
        vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
        vecs[2]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0};
        vecs[3]  = '{32'h1234,       32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234,       1'b1};
        vecs[4]  = '{32'h1234,       32'd0,          1'b1, 32'hFFFF_FFFF,  32'h1234,       1'b1};
        vecs[5]  = '{32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1};
        vecs[6]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0};
        vecs[7]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0};
        vecs[8]  = '{32'd0,          32'd5,          1'b0, 32'd0,          32'd0,          1'b0};
        vecs[9]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[10] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0,          1'b0};
        vecs[11] = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE,  1'b0};
        vecs[12] = '{32'd5,          32'd10,         1'b0, 32'd0,          32'd5,          1'b0};

        reset_n = 1'b0; E_src1 = '0; E_src2 = '0;
        E_div_start = 1'b0; E_div_signed = 1'b0; M_flush = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(D_busy), 32'd0);
        check("rst_done", 32'(D_done), 32'd0);
        check("rst_quotient", D_quotient, 32'd0);
        check("rst_remainder", D_remainder, 32'd0);
        check("rst_div_zero", 32'(D_div_zero), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Table vectors with one idle cycle between operations
        for (int i = 0; i < 13; i++) begin
            do_div(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].q, vecs[i].r, vecs[i].z, 0);
            @(negedge clk);
        end

        // Random operands against a behavioural model
        for (int i = 0; i < 8; i++) begin
            ua = $urandom;
            ub = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (ub == 32'd0) ub = 32'd3;
            if (i < 4) begin
                do_div(ua, ub, 1'b0, ua / ub, ua % ub, 1'b0, 0);
            end else begin
                if (ua == 32'h8000_0000) ua = 32'h8000_0001;
                sa = $signed(ua); sb = $signed(ub);
                do_div(ua, ub, 1'b1, 32'(sa / sb), 32'(sa % sb), 1'b0, 0);
            end
            @(negedge clk);
        end

        // Second start during RUN must be ignored
        do_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 5);

        // Back-to-back: new start in the D_done cycle is accepted
        do_div(32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 0);
        do_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 0);
        @(negedge clk);

        // Flush at T+10: no done, results held, then 9/4 started at T+12
        E_src1 = 32'd50; E_src2 = 32'd5; E_div_signed = 1'b0; E_div_start = 1'b1;
        @(negedge clk);
        E_div_start = 1'b0;
        repeat (8) @(negedge clk);
        M_flush = 1'b1;
        E_div_start = 1'b1;
        @(negedge clk);
        M_flush = 1'b0;
        E_div_start = 1'b0;
        check("flush_busy", 32'(D_busy), 32'd0);
        check("flush_done", 32'(D_done), 32'd0);
        check("flush_quotient_held", D_quotient, 32'd14);
        check("flush_remainder_held", D_remainder, rexp(32'd2));
        check("flush_div_zero_held", 32'(D_div_zero), 32'd0);
        @(negedge clk);
        do_div(32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 1'b0, 0);
        @(negedge clk);

        // Asynchronous reset mid-RUN clears outputs at once, no done follows
        E_src1 = 32'd100; E_src2 = 32'd7; E_div_start = 1'b1;
        @(negedge clk);
        E_div_start = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(D_busy), 32'd0);
        check("arst_done", 32'(D_done), 32'd0);
        check("arst_quotient", D_quotient, 32'd0);
        check("arst_remainder", D_remainder, 32'd0);
        check("arst_div_zero", 32'(D_div_zero), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check("arst_idle_busy", 32'(D_busy), 32'd0);

        // Recovery after reset
        do_div(32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 1'b0, 0);
        repeat (3) @(negedge clk);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
